// File: rtl/rpn_gw_from_network_bridge_router_if.sv
// AXI-Stream bundle shared by the router input and output sides.
// VR_W sets the number of valid/ready lanes: 1 on the input, NUM_CH on the output.
// The payload is common to all lanes.
//   master: drives tvalid and the payload, samples tready
//   slave : samples tvalid and the payload, drives tready
interface rpn_gw_from_network_bridge_router_if #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = DATA_W / 8,
    parameter int ID_W   = 16,
    parameter int USER_W = 64,
    parameter int VR_W   = 1
);
    logic [VR_W-1:0]   tvalid;
    logic [VR_W-1:0]   tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [ID_W-1:0]   tid;
    logic [ID_W-1:0]   tdest;
    logic [USER_W-1:0] tuser;
    logic              tlast;

    modport master (output tvalid, tdata, tkeep, tid, tdest, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tid, tdest, tuser, tlast, output tready);
endinterface

// File: rtl/rpn_gw_from_network_bridge_router.sv
// N-way packet router from the network bridge to the RPN channels.
// The first beat of each packet is classified on tdata[MSG_TYPE_WIDTH-1:0].
// The whole packet then goes to the lowest-index matching channel, or it is dropped.
// One register slice on the output gives full throughput.
// Ports:
//   i_clk, i_ap_rst      clock and asynchronous active-high reset
//   from_network_bridge  AXIS slave, 1 valid/ready lane
//   to_rpn               AXIS master, NUM_CH valid/ready lanes, payload broadcast
// Optional statistics, enabled when RPN_GW_ROUTER_STATS_EN is defined:
//   o_pkt_count   per-channel count of forwarded packets
//   o_drop_count  count of dropped packets
//   i_stats_clr   synchronous clear of both counters
module rpn_gw_from_network_bridge_router #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int IP_PORT_WIDTH   = 16,
    parameter int TUSER_WIDTH     = 64,
    parameter int MSG_TYPE_WIDTH  = 8,
    parameter int NUM_CH          = 2,
    parameter logic [NUM_CH*MSG_TYPE_WIDTH-1:0] CH_TYPE_BASE = {8'h10, 8'h00},
    parameter logic [NUM_CH*MSG_TYPE_WIDTH-1:0] CH_TYPE_MASK = {8'hF0, 8'hF0}
) (
    input  logic i_clk,
    input  logic i_ap_rst,
    rpn_gw_from_network_bridge_router_if.slave  from_network_bridge,
    rpn_gw_from_network_bridge_router_if.master to_rpn
`ifdef RPN_GW_ROUTER_STATS_EN
    ,
    input  logic                   i_stats_clr,
    output logic [NUM_CH*32-1:0]   o_pkt_count,
    output logic [31:0]            o_drop_count
`endif
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic                       out_valid_q, out_valid_d;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q;
    logic [AXIS_KEEP_WIDTH-1:0] tkeep_q;
    logic [IP_PORT_WIDTH-1:0]   tid_q, tdest_q;
    logic [TUSER_WIDTH-1:0]     tuser_q;
    logic                       tlast_q;

    logic [MSG_TYPE_WIDTH-1:0]  msg_type;
    logic                       hit_any;
    logic [SEL_W-1:0]           hit_idx;
    logic                       discard, drain, in_hs, load;

    // Descending scan, so the lowest matching index is the one that remains.
    always_comb begin
        msg_type = from_network_bridge.tdata[MSG_TYPE_WIDTH-1:0];
        hit_any  = 1'b0;
        hit_idx  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if ((msg_type & CH_TYPE_MASK[k*MSG_TYPE_WIDTH +: MSG_TYPE_WIDTH])
                    == CH_TYPE_BASE[k*MSG_TYPE_WIDTH +: MSG_TYPE_WIDTH]) begin
                hit_any = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
    end

    // Discarded beats never touch the output slice, so back-pressure cannot stall them.
    assign discard = (state_q == ST_DROP) || ((state_q == ST_IDLE) && !hit_any);
    assign drain   = out_valid_q && to_rpn.tready[sel_q];
    assign from_network_bridge.tready = !i_ap_rst && (discard || !out_valid_q || drain);
    assign in_hs   = from_network_bridge.tvalid && from_network_bridge.tready;
    assign load    = in_hs && !discard;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        if (drain) out_valid_d = 1'b0;
        if (load)  out_valid_d = 1'b1;
        if (in_hs) begin
            case (state_q)
                ST_IDLE: begin
                    if (hit_any) begin
                        // The slice is empty or draining now, so switching channel is safe.
                        sel_d   = hit_idx;
                        state_d = from_network_bridge.tlast ? ST_IDLE : ST_FWD;
                    end else begin
                        state_d = from_network_bridge.tlast ? ST_IDLE : ST_DROP;
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (from_network_bridge.tlast) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_ap_rst) begin
        if (i_ap_rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tid_q       <= '0;
            tdest_q     <= '0;
            tuser_q     <= '0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            if (load) begin
                tdata_q <= from_network_bridge.tdata;
                tkeep_q <= from_network_bridge.tkeep;
                tid_q   <= from_network_bridge.tid;
                tdest_q <= from_network_bridge.tdest;
                tuser_q <= from_network_bridge.tuser;
                tlast_q <= from_network_bridge.tlast;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            to_rpn.tvalid[k] = out_valid_q && (sel_q == SEL_W'(k));
        end
    end

    assign to_rpn.tdata = tdata_q;
    assign to_rpn.tkeep = tkeep_q;
    assign to_rpn.tid   = tid_q;
    assign to_rpn.tdest = tdest_q;
    assign to_rpn.tuser = tuser_q;
    assign to_rpn.tlast = tlast_q;

`ifdef RPN_GW_ROUTER_STATS_EN
    logic [31:0] pkt_cnt_q [NUM_CH];
    logic [31:0] drop_cnt_q;
    logic        drop_evt;

    // A packet is dropped when its last beat is discarded in DROP or in IDLE (single beat).
    assign drop_evt = in_hs && discard && from_network_bridge.tlast;

    always_ff @(posedge i_clk or posedge i_ap_rst) begin
        if (i_ap_rst) begin
            drop_cnt_q <= '0;
            for (int k = 0; k < NUM_CH; k++) pkt_cnt_q[k] <= '0;
        end else if (i_stats_clr) begin
            drop_cnt_q <= '0;
            for (int k = 0; k < NUM_CH; k++) pkt_cnt_q[k] <= '0;
        end else begin
            if (drop_evt && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_q <= drop_cnt_q + 32'd1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (to_rpn.tvalid[k] && to_rpn.tready[k] && tlast_q
                        && (pkt_cnt_q[k] != 32'hFFFF_FFFF))
                    pkt_cnt_q[k] <= pkt_cnt_q[k] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) o_pkt_count[k*32 +: 32] = pkt_cnt_q[k];
    end
    assign o_drop_count = drop_cnt_q;
`endif
endmodule
